alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised registered ALU, the successor to the single-cycle combinational ALU.
//   Adds ADC/SBC, MOV pass-through and an iterative shift-add multiply (MUL).
//   Uses a Start/Busy/Done handshake and registered Result and NZCV flags.
//   Sits between register-file read and writeback; the control unit stalls on Busy.
// PARAMETERS
//   WIDTH  32  datapath width in bits (>= 4); also MUL iteration count
//   CNT_W  6   width of the MUL iteration counter; must satisfy 2**CNT_W > WIDTH
// PORTS
//   CLK        in   1      clock, rising edge
//   RESETn     in   1      asynchronous active-low reset
//   Start      in   1      request; sampled only when the unit can accept (IDLE or DONE)
//   ALUOp      in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADC, 101 SBC, 110 MUL, 111 MOV
//   Src_A      in   WIDTH  operand A
//   Src_B      in   WIDTH  operand B
//   C_Flag     in   1      carry-in for ADC/SBC
//   Busy       out  1      MUL in progress; Start is ignored while high
//   Done       out  1      one-cycle pulse: ALUResult/ALUFlags updated this cycle
//   ALUResult  out  WIDTH  registered result; holds until the next Done
//   ALUFlags   out  4      registered {N,Z,C,V}; holds until the next Done
// BEHAVIOUR
//   Reset (RESETn=0, any time, async): state=IDLE; Busy=0, Done=0, ALUResult=0, ALUFlags=0.
//     Any in-flight MUL is discarded. No Done after reset release until a new Start.
//   States:
//     IDLE: Start=1 -> op != MUL: go to DONE; op == MUL: go to RUN. Start=0 -> stay.
//     RUN: cnt decrements each edge; after cnt reaches 0 (WIDTH edges) -> DONE.
//     DONE: Done=1 for this cycle only. Start=1 here is accepted as in IDLE (back-to-back);
//       otherwise -> IDLE.
//   Operands and ALUOp are latched at the accepting edge; later changes do not affect the op.
//   Latency, with Start sampled at the edge ending cycle k:
//     single-cycle ops: Done=1 in cycle k+1; Busy stays 0.
//     MUL: Busy=1 in cycles k+1..k+WIDTH; Done=1 in cycle k+WIDTH+1.
//   Arithmetic uses a (WIDTH+1)-bit sum S = {0,A} + {0,B'} + cin:
//     ADD: B'=B,  cin=0       SUB: B'=~B, cin=1
//     ADC: B'=B,  cin=C_Flag  SBC: B'=~B, cin=C_Flag
//     C = S[WIDTH]. For SUB/SBC, C=1 means no borrow.
//     V, add forms: (A[m]~^B[m]) & (A[m]^S[m]); sub forms: (A[m]^B[m]) & (A[m]^S[m]); m=WIDTH-1.
//   AND/OR/MOV (MOV result = Src_B): C=0, V=0.
//   MUL: result = low WIDTH bits of A*B, unsigned shift-add, one multiplier bit per RUN edge.
//     C and V keep their previous ALUFlags values.
//   All ops: N = result[m]; Z = (result == 0).
//   Between Done pulses, ALUResult/ALUFlags hold their values. During RUN they show the
//     previous result, never partial products.
// TESTING (WIDTH=32)
//   RESETn=0 mid-MUL (cycle 10 of 32) -> Busy=0, Done=0, ALUResult=0, ALUFlags=0 at once;
//     no Done after release.
//   ADD 0x7FFFFFFF+1 -> next cycle Done=1, Result=0x80000000, NZCV=1001; Busy never high.
//   SUB 5-5 -> Result=0, NZCV=0110. SBC 0-0 with C_Flag=0 -> Result=0xFFFFFFFF, NZCV=1000.
//   ADC 0xFFFFFFFF+0 with C_Flag=1 -> Result=0, NZCV=0110.
//   MUL 0x00010001*0x00010001 -> Busy cycles k+1..k+32; Done at k+33;
//     Result=0x00020001; C,V unchanged.
//   Start pulsed while Busy -> ignored. Start held in the DONE cycle -> new op accepted;
//     Done pulses on consecutive single-cycle ops.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and the sequential ALU.
// The ALU side uses the slave modport.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       ALUOp;
  logic [WIDTH-1:0] Src_A;
  logic [WIDTH-1:0] Src_B;
  logic             C_Flag;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;

  modport master (
    output Start, ALUOp, Src_A, Src_B, C_Flag,
    input  Busy, Done, ALUResult, ALUFlags
  );

  modport slave (
    input  Start, ALUOp, Src_A, Src_B, C_Flag,
    output Busy, Done, ALUResult, ALUFlags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a Start/Busy/Done handshake. Single-cycle ops are resolved
// at the accepting edge; MUL iterates one multiplier bit per edge.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        CLK,
  input  logic        RESETn,
  alu_seq_if.slave    bus
);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, mul_sum;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  logic             accept, is_mul;
  logic             sub, cin;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Start is only honoured when the unit can take a new op (IDLE or DONE).
  assign accept = bus.Start && (state != RUN);
  assign is_mul = (bus.ALUOp == 3'b110);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = is_mul ? RUN : DONE;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = bus.Start ? (is_mul ? RUN : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALUOp[0] selects the subtract form, ALUOp[2] selects external carry-in.
  always_comb begin
    sub     = bus.ALUOp[0];
    b_op    = sub ? ~bus.Src_B : bus.Src_B;
    cin     = bus.ALUOp[2] ? bus.C_Flag : sub;
    sum     = {1'b0, bus.Src_A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALUOp)
      3'b000, 3'b001, 3'b100, 3'b101: begin
        alu_res = sum[M:0];
        alu_c   = sum[WIDTH];
        alu_v   = sub ? ((bus.Src_A[M] ^ bus.Src_B[M]) & (bus.Src_A[M] ^ sum[M]))
                      : ((bus.Src_A[M] ~^ bus.Src_B[M]) & (bus.Src_A[M] ^ sum[M]));
      end
      3'b010:  alu_res = bus.Src_A & bus.Src_B;
      3'b011:  alu_res = bus.Src_A | bus.Src_B;
      3'b111:  alu_res = bus.Src_B;
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  // Result/flags only change on the edge that makes Done visible, so RUN never
  // exposes partial products.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      flags  <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= bus.Src_A;
        mplier <= bus.Src_B;
        acc    <= '0;
        cnt    <= CNT_W'(WIDTH - 1);
      end else begin
        result <= alu_res;
        flags  <= {alu_res[M], alu_res == '0, alu_c, alu_v};
      end
    end else if (state == RUN) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        result <= mul_sum;
        flags  <= {mul_sum[M], mul_sum == '0, flags[1:0]};
      end
    end
  end

  assign bus.Busy      = (state == RUN);
  assign bus.Done      = (state == DONE);
  assign bus.ALUResult = result;
  assign bus.ALUFlags  = flags;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected {flags,result} pushed when an op is
// issued, popped and compared when Done is observed.
module tb_alu_seq;
  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_ADC = 3'b100, OP_SBC = 3'b101,
                         OP_MUL = 3'b110, OP_MOV = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W), .CNT_W(6)) u_dut (.CLK(clk), .RESETn(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [35:0] sb_q[$];
  logic [3:0]  exp_prev = 4'h0;

  // Independent reference built on 64-bit integer arithmetic.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci,
                                        input logic [3:0] prev);
    longint ua, ub, sa, sb, u, s;
    logic [31:0] r;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        u = ua + ub + ((op == OP_ADC && ci) ? 1 : 0);
        s = sa + sb + ((op == OP_ADC && ci) ? 1 : 0);
        r = u[31:0]; c = (u > 64'sh0FFFFFFFF);
        v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      OP_SUB, OP_SBC: begin
        u = ua - ub - ((op == OP_SBC && !ci) ? 1 : 0);
        s = sa - sb - ((op == OP_SBC && !ci) ? 1 : 0);
        r = u[31:0]; c = (u >= 0);
        v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_MOV: r = b;
      default: begin
        u = ua * ub;
        r = u[31:0]; c = prev[1]; v = prev[0];
      end
    endcase
    return {r[31], r == 32'h0, c, v, r};
  endfunction

  // Drives one Start pulse from a negedge; returns at the negedge of cycle k+1
  // with operands scrambled to prove they were latched.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ci);
    logic [35:0] e;
    e = model(op, a, b, ci, exp_prev);
    sb_q.push_back(e);
    exp_prev = e[35:32];
    bus.ALUOp = op; bus.Src_A = a; bus.Src_B = b; bus.C_Flag = ci; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Src_A = $urandom; bus.Src_B = $urandom; bus.C_Flag = ~ci;
    bus.ALUOp = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int cyc, output int busy);
    cyc = 1; busy = 0;
    while (!bus.Done && cyc < 200) begin
      if (bus.Busy) busy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.ALUOp = OP_ADD; bus.Src_A = '0; bus.Src_B = '0; bus.C_Flag = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.Done); end
    checks++; if (bus.ALUResult !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", bus.ALUResult); end
    checks++; if (bus.ALUFlags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b want=0000", bus.ALUFlags); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_single(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic ci);
    int cyc, busy;
    logic [35:0] e;
    send(op, a, b, ci);
    wait_done(cyc, busy);
    e = sb_q.pop_front();
    checks++; if (cyc != 1) begin failures++; $display("FAIL %s_latency got=%0d want=1", name, cyc); end
    checks++; if (busy != 0) begin failures++; $display("FAIL %s_busy got=%0d want=0", name, busy); end
    checks++; if (bus.ALUResult !== e[31:0]) begin failures++; $display("FAIL %s_result got=%h want=%h", name, bus.ALUResult, e[31:0]); end
    checks++; if (bus.ALUFlags !== e[35:32]) begin failures++; $display("FAIL %s_flags got=%b want=%b", name, bus.ALUFlags, e[35:32]); end
    @(negedge clk);
  endtask

  task automatic test_arith;
    run_single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
    checks++; if (exp_prev !== 4'b1001) begin failures++; $display("FAIL add_ovf_ref got=%b want=1001", exp_prev); end
    run_single("sub_eq", OP_SUB, 32'd5, 32'd5, 1'b0);
    run_single("sbc_zero", OP_SBC, 32'h0, 32'h0, 1'b0);
    run_single("adc_wrap", OP_ADC, 32'hFFFFFFFF, 32'h0, 1'b1);
    run_single("and", OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 1'b1);
    run_single("or", OP_OR, 32'h8000_0001, 32'h0000_1000, 1'b1);
    run_single("mov", OP_MOV, 32'h1234_5678, 32'h0, 1'b1);
    run_single("sub_neg", OP_SUB, 32'h8000_0000, 32'h1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == OP_MUL) op = OP_ADC;
      run_single("rand", op, $urandom, $urandom, 1'($urandom));
    end
  endtask

  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    int cyc, busy;
    logic [35:0] e;
    send(OP_MUL, a, b, 1'b0);
    wait_done(cyc, busy);
    e = sb_q.pop_front();
    checks++; if (cyc != 33) begin failures++; $display("FAIL %s_latency got=%0d want=33", name, cyc); end
    checks++; if (busy != 32) begin failures++; $display("FAIL %s_busy got=%0d want=32", name, busy); end
    checks++; if (bus.ALUResult !== e[31:0]) begin failures++; $display("FAIL %s_result got=%h want=%h", name, bus.ALUResult, e[31:0]); end
    checks++; if (bus.ALUFlags !== e[35:32]) begin failures++; $display("FAIL %s_flags got=%b want=%b", name, bus.ALUFlags, e[35:32]); end
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [31:0] held;
    // C=1,V=0 from SUB must survive the MUL.
    run_single("mul_pre", OP_SUB, 32'd9, 32'd3, 1'b0);
    held = bus.ALUResult;
    send(OP_MUL, 32'h0001_0001, 32'h0001_0001, 1'b0);
    repeat (5) begin
      checks++; if (bus.ALUResult !== held) begin failures++; $display("FAIL mul_hold got=%h want=%h", bus.ALUResult, held); end
      @(negedge clk);
    end
    begin
      int cyc, busy;
      logic [35:0] e;
      wait_done(cyc, busy);
      e = sb_q.pop_front();
      checks++; if (cyc != 28) begin failures++; $display("FAIL mul_lat got=%0d want=28", cyc); end
      checks++; if (bus.ALUResult !== 32'h0002_0001) begin failures++; $display("FAIL mul_result got=%h want=00020001", bus.ALUResult); end
      checks++; if (bus.ALUFlags !== e[35:32]) begin failures++; $display("FAIL mul_flags got=%b want=%b", bus.ALUFlags, e[35:32]); end
    end
    @(negedge clk);
    run_single("mul_pre2", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
    run_mul("mul_rand", $urandom, $urandom);
    run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  task automatic test_ignore_busy;
    int cyc, busy;
    logic [35:0] e;
    send(OP_MUL, 32'd1234, 32'd5678, 1'b0);
    repeat (4) @(negedge clk);
    bus.ALUOp = OP_MOV; bus.Src_B = 32'hDEAD_BEEF; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(cyc, busy);
    e = sb_q.pop_front();
    checks++; if (cyc != 28) begin failures++; $display("FAIL ign_latency got=%0d want=28", cyc); end
    checks++; if (bus.ALUResult !== e[31:0]) begin failures++; $display("FAIL ign_result got=%h want=%h", bus.ALUResult, e[31:0]); end
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL ign_after got=%b%b want=00", bus.Done, bus.Busy); end
  endtask

  task automatic test_back_to_back;
    logic [35:0] e;
    logic [2:0]  ops [3] = '{OP_ADD, OP_SUB, OP_OR};
    logic [31:0] as  [3] = '{32'h10, 32'h3, 32'hA000_0000};
    logic [31:0] bs  [3] = '{32'h20, 32'h7, 32'h0000_000A};
    for (int i = 0; i < 3; i++) begin
      e = model(ops[i], as[i], bs[i], 1'b0, exp_prev);
      sb_q.push_back(e);
      exp_prev = e[35:32];
      bus.ALUOp = ops[i]; bus.Src_A = as[i]; bus.Src_B = bs[i]; bus.C_Flag = 1'b0;
      bus.Start = 1'b1;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL b2b_done%0d got=%b want=1", i, bus.Done); end
      checks++; if ({bus.ALUFlags, bus.ALUResult} !== e) begin failures++; $display("FAIL b2b_res%0d got=%h want=%h", i, {bus.ALUFlags, bus.ALUResult}, e); end
    end
    bus.Start = 1'b0;
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b want=0", bus.Done); end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    run_single("pre_rst", OP_SUB, 32'd1, 32'd2, 1'b0);
    send(OP_MUL, 32'h0001_0001, 32'h0001_0001, 1'b0);
    repeat (9) @(negedge clk);
    checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b want=1", bus.Busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got=%b%b want=00", bus.Busy, bus.Done); end
    checks++; if (bus.ALUResult !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h want=0", bus.ALUResult); end
    checks++; if (bus.ALUFlags !== 4'h0) begin failures++; $display("FAIL rst_mid_flags got=%b want=0000", bus.ALUFlags); end
    sb_q.delete();
    exp_prev = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
